// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges main-pipe and mul/div results onto one registered W port
// and tracks pending mul/div destinations. Define WB_DRAIN_STALL_EN to add pipe_hold.
module wb_arbiter #(
   parameter int XLEN      = 32,
   parameter int BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pipe_we,
   input  logic [4:0]      pipe_rd,
   input  logic [XLEN-1:0] pipe_data,
   input  logic            md_valid,
   input  logic [4:0]      md_rd,
   input  logic [XLEN-1:0] md_data,
   output logic            md_ready,
   input  logic            issue_valid,
   input  logic [4:0]      issue_rd,
   input  logic [31:0]     Ins_D,
   output logic            stall_D,
`ifdef WB_DRAIN_STALL_EN
   output logic            pipe_hold,
`endif
   output logic            RegWrite_W,
   output logic [4:0]      rd_W,
   output logic [XLEN-1:0] Result_W
);

   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W = $clog2(BUF_DEPTH + 1);

   logic [4:0]      buf_rd   [BUF_DEPTH];
   logic [XLEN-1:0] buf_data [BUF_DEPTH];
   logic [PTR_W-1:0] head, tail;
   logic [CNT_W-1:0] count;
   logic [31:0]      pending;
   logic [31:0]      set_mask, clr_mask;

   logic pipe_win_p0, do_pop_p0, do_push_p0;
   logic unused_ins;

   assign unused_ins = ^{Ins_D[31:25], Ins_D[14:12], Ins_D[6:0]};

   // Decode-side view: readiness comes from the registered count only.
   assign md_ready    = !rst && (count < CNT_W'(BUF_DEPTH));
   assign pipe_win_p0 = pipe_we && (pipe_rd != 5'd0);
   assign do_pop_p0   = !pipe_win_p0 && (count != '0);
   assign do_push_p0  = md_valid && md_ready && (md_rd != 5'd0);

   assign stall_D = !rst && (pending[Ins_D[19:15]] | pending[Ins_D[24:20]] | pending[Ins_D[11:7]]);

`ifdef WB_DRAIN_STALL_EN
   assign pipe_hold = (count == CNT_W'(BUF_DEPTH)) && !rst;
`endif

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (issue_valid && (issue_rd != 5'd0))
         set_mask[issue_rd] = 1'b1;
      if (do_pop_p0)
         clr_mask[buf_rd[head]] = 1'b1;
   end

   // Buffer storage holds data only; validity is carried by count/pointers.
   always_ff @(posedge clk) begin
      if (do_push_p0) begin
         buf_rd[tail]   <= md_rd;
         buf_data[tail] <= md_data;
      end
   end

   // W stage register, FIFO control and scoreboard.
   always_ff @(posedge clk) begin
      if (rst) begin
         RegWrite_W <= 1'b0;
         rd_W       <= 5'd0;
         Result_W   <= '0;
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         pending    <= '0;
      end else begin
         RegWrite_W <= pipe_win_p0 || do_pop_p0;
         if (pipe_win_p0) begin
            rd_W     <= pipe_rd;
            Result_W <= pipe_data;
         end else if (do_pop_p0) begin
            rd_W     <= buf_rd[head];
            Result_W <= buf_data[head];
         end
         if (do_pop_p0)
            head <= head + PTR_W'(1);
         if (do_push_p0)
            tail <= tail + PTR_W'(1);
         case ({do_push_p0, do_pop_p0})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         // Set after clear so a reissued destination stays outstanding.
         pending <= ((pending & ~clr_mask) | set_mask) & ~32'h1;
      end
   end

endmodule
